video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_pkg.sv | 33 +++
 rtl/video_timing_core.sv | 62 ++++++
 rtl/video_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_pkg.sv
// Shared colour constants, pattern codes and the colour-bar palette lookup.
package video_pattern_pkg;

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] BLACK   = 24'h000000;

    localparam logic [2:0] PAT_BARS    = 3'd0;
    localparam logic [2:0] PAT_CHECKER = 3'd1;
    localparam logic [2:0] PAT_GRAY    = 3'd2;
    localparam logic [2:0] PAT_SOLID   = 3'd3;
    localparam logic [2:0] PAT_BOX     = 3'd4;

    // Classic SMPTE-like ordering, brightest first.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return WHITE;
            3'd1:    return YELLOW;
            3'd2:    return CYAN;
            3'd3:    return GREEN;
            3'd4:    return MAGENTA;
            3'd5:    return RED;
            3'd6:    return BLUE;
            default: return BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters plus combinational sync / data-enable / frame-start decode.
// Line and frame order: sync, back porch, active, front porch.
module video_timing_core #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int CW       = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    output logic [CW-1:0] o_h_cnt,
    output logic [CW-1:0] o_v_cnt,
    output logic          o_hs_act,
    output logic          o_vs_act,
    output logic          o_h_act,
    output logic          o_de,
    output logic          o_frame_start
);
    localparam logic [CW-1:0] H_LAST = CW'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] H_AS   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_AE   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_AS   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_AE   = CW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CW-1:0] H_SW   = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SW   = CW'(V_SYNC);

    logic [CW-1:0] r_h_cnt, r_v_cnt;
    logic          w_v_act;

    // Raster scan; disabling parks the counters at the frame origin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CW'(1);
        end
    end

    assign w_v_act       = (r_v_cnt >= V_AS) && (r_v_cnt < V_AE);
    assign o_h_act       = (r_h_cnt >= H_AS) && (r_h_cnt < H_AE);
    assign o_de          = o_h_act && w_v_act;
    assign o_hs_act      = r_h_cnt < H_SW;
    assign o_vs_act      = r_v_cnt < V_SW;
    assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern generator on top of the timing core. Every output is registered
// one cycle after the counter state it describes, so all outputs stay aligned.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int NUM_BARS = 8,
    parameter int BOX_SIZE = 64,
    parameter int CW       = 12
) (
    input  logic          pixel_clk,
    input  logic          sys_rst_n,
    input  logic          enable,
    input  logic [2:0]    pattern_sel,
    input  logic [23:0]   solid_rgb,
    output logic          video_hs,
    output logic          video_vs,
    output logic          video_de,
    output logic [23:0]   video_rgb,
    output logic [CW-1:0] pixel_xpos,
    output logic [CW-1:0] pixel_ypos,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam logic [CW-1:0] H_AS     = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_AS     = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] BAR_W_M1 = CW'(H_ACTIVE / NUM_BARS - 1);
    localparam logic [2:0]    LAST_BAR = 3'(NUM_BARS - 1);
    localparam logic [CW-1:0] BOX_SZ   = CW'(BOX_SIZE);
    localparam logic [CW-1:0] BOX_XMAX = CW'(H_ACTIVE - BOX_SIZE);
    localparam logic [CW-1:0] BOX_Y0   = CW'(V_ACTIVE / 2 - BOX_SIZE / 2);

    logic [CW-1:0] w_h_cnt, w_v_cnt, w_x, w_y;
    logic          w_hs_act, w_vs_act, w_h_act, w_de, w_fs, w_in_box;
    logic [23:0]   w_rgb;

    logic [2:0]    r_pat, r_bar_idx;
    logic [CW-1:0] r_bar_px, r_box_x, r_box_cur;
    logic [15:0]   r_frame_cnt;
    logic          r_hs, r_vs, r_de, r_fs;
    logic [23:0]   r_rgb;
    logic [CW-1:0] r_xpos, r_ypos;

    video_timing_core #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CW(CW)
    ) u_timing (
        .i_clk        (pixel_clk),
        .i_rst_n      (sys_rst_n),
        .i_enable     (enable),
        .o_h_cnt      (w_h_cnt),
        .o_v_cnt      (w_v_cnt),
        .o_hs_act     (w_hs_act),
        .o_vs_act     (w_vs_act),
        .o_h_act      (w_h_act),
        .o_de         (w_de),
        .o_frame_start(w_fs)
    );

    assign w_x      = w_de ? (w_h_cnt - H_AS) : '0;
    assign w_y      = w_de ? (w_v_cnt - V_AS) : '0;
    assign w_in_box = (w_x >= r_box_cur) && (w_x < r_box_cur + BOX_SZ) &&
                      (w_y >= BOX_Y0) && (w_y < BOX_Y0 + BOX_SZ);

    // Bar index tracks x with a pixel-in-bar counter; the last bar soaks up the remainder.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (!enable || !w_h_act) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_px == BAR_W_M1 && r_bar_idx != LAST_BAR) begin
            r_bar_px  <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_px  <= r_bar_px + CW'(1);
        end
    end

    // Per-frame state: pattern and box position are latched only at frame start,
    // so a frame is never torn. r_box_x is the position the next frame will use.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pat       <= PAT_BARS;
            r_box_x     <= '0;
            r_box_cur   <= '0;
            r_frame_cnt <= '0;
        end else if (enable && w_fs) begin
            r_pat       <= pattern_sel;
            r_box_cur   <= r_box_x;
            r_box_x     <= (r_box_x >= BOX_XMAX) ? '0 : r_box_x + CW'(1);
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Pixel colour for the current counter position; black outside active video.
    always_comb begin
        w_rgb = BLACK;
        case (r_pat)
            PAT_BARS:    w_rgb = bar_color(r_bar_idx);
            PAT_CHECKER: w_rgb = (w_x[5] ^ w_y[5]) ? WHITE : BLACK;
            PAT_GRAY:    w_rgb = {3{w_x[7:0]}};
            PAT_SOLID:   w_rgb = solid_rgb;
            PAT_BOX:     w_rgb = w_in_box ? WHITE : BLUE;
            default:     w_rgb = BLACK;
        endcase
        if (!w_de) w_rgb = BLACK;
    end

    // Output register stage; disabled or reset means idle levels.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hs <= ~HS_POL; r_vs <= ~VS_POL; r_de <= 1'b0; r_fs <= 1'b0;
            r_rgb <= '0; r_xpos <= '0; r_ypos <= '0;
        end else if (!enable) begin
            r_hs <= ~HS_POL; r_vs <= ~VS_POL; r_de <= 1'b0; r_fs <= 1'b0;
            r_rgb <= '0; r_xpos <= '0; r_ypos <= '0;
        end else begin
            r_hs   <= w_hs_act ? HS_POL : ~HS_POL;
            r_vs   <= w_vs_act ? VS_POL : ~VS_POL;
            r_de   <= w_de;
            r_fs   <= w_fs;
            r_rgb  <= w_rgb;
            r_xpos <= w_x;
            r_ypos <= w_y;
        end
    end

    assign video_hs    = r_hs;
    assign video_vs    = r_vs;
    assign video_de    = r_de;
    assign video_rgb   = r_rgb;
    assign pixel_xpos  = r_xpos;
    assign pixel_ypos  = r_ypos;
    assign frame_start = r_fs;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a tiny 25x12 raster.
module tb_video_pattern_gen;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
    localparam int VA = 8, VFP = 1, VS = 2, VBP = 1;
    localparam int NB = 3, BOX = 4, CW = 12;
    localparam int HT = HS + HBP + HA + HFP;   // 25
    localparam int VT = VS + VBP + VA + VFP;   // 12
    localparam int FT = HT * VT;               // 300
    localparam logic [23:0] BAR_TBL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          clk, rst_n, enable;
    logic [2:0]    pattern_sel;
    logic [23:0]   solid_rgb;
    logic          video_hs, video_vs, video_de, frame_start;
    logic [23:0]   video_rgb;
    logic [CW-1:0] pixel_xpos, pixel_ypos;
    logic [15:0]   frame_cnt;
    logic [67:0]   obs;

    int checks = 0, failures = 0;

    // reference model state
    int          m_pos, m_box_cur, m_box_next;
    logic [2:0]  m_pat;
    logic [15:0] m_fc;
    logic [67:0] m_exp;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .NUM_BARS(NB), .BOX_SIZE(BOX), .CW(CW)
    ) dut (
        .pixel_clk(clk), .sys_rst_n(rst_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
        .video_rgb(video_rgb), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    assign obs = {video_hs, video_vs, video_de, video_rgb, pixel_xpos, pixel_ypos, frame_start, frame_cnt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs for frame position pos (pos<0 means idle).
    function automatic logic [67:0] exp_out(input int pos, input logic [2:0] pat, input int box,
                                            input logic [23:0] solid, input logic [15:0] fc);
        int hc, vc, x, y, bar;
        logic hs_, vs_, de_;
        logic [23:0] c;
        if (pos < 0) return {3'b000, 24'h0, 12'h0, 12'h0, 1'b0, fc};
        hc = pos % HT; vc = pos / HT;
        hs_ = hc < HS;
        vs_ = vc < VS;
        de_ = (hc >= HS + HBP) && (hc < HS + HBP + HA) && (vc >= VS + VBP) && (vc < VS + VBP + VA);
        x = de_ ? hc - (HS + HBP) : 0;
        y = de_ ? vc - (VS + VBP) : 0;
        c = 24'h0;
        if (de_) begin
            case (pat)
                3'd0: begin bar = x / (HA / NB); if (bar > NB - 1) bar = NB - 1; c = BAR_TBL[bar]; end
                3'd1: c = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                3'd2: c = {3{8'(x)}};
                3'd3: c = solid;
                3'd4: c = (x >= box && x < box + BOX && y >= VA/2 - BOX/2 && y < VA/2 - BOX/2 + BOX)
                          ? 24'hFFFFFF : 24'h0000FF;
                default: c = 24'h0;
            endcase
        end
        return {hs_, vs_, de_, c, 12'(x), 12'(y), pos == 0, fc};
    endfunction

    // Advance one clock: model consumes the inputs seen at the edge; returns at negedge.
    task automatic tick();
        int p;
        @(posedge clk);
        if (enable) begin
            p = m_pos;
            if (p == 0) begin
                m_pat      = pattern_sel;
                m_box_cur  = m_box_next;
                m_box_next = (m_box_next == HA - BOX) ? 0 : m_box_next + 1;
                m_fc       = m_fc + 16'd1;
            end
            m_exp = exp_out(p, m_pat, m_box_cur, solid_rgb, m_fc);
            m_pos = (p + 1) % FT;
        end else begin
            m_exp = exp_out(-1, m_pat, m_box_cur, solid_rgb, m_fc);
            m_pos = 0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0;
        m_pos = 0; m_pat = 3'd0; m_box_cur = 0; m_box_next = 0; m_fc = 16'h0;
        m_exp = exp_out(-1, 3'd0, 0, 24'h0, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== exp_out(-1, 3'd0, 0, 24'h0, 16'h0)) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_out(-1, 3'd0, 0, 24'h0, 16'h0));
        end
        apply_reset();
    endtask

    task automatic test_sweep();
        int de_n = 0, hs_n = 0, fs_n = 0, last_fs = -1;
        pattern_sel = 3'd0; enable = 1'b1;
        for (int i = 0; i < 3 * FT; i++) begin
            tick();
            checks++;
            if (obs !== m_exp) begin
                failures++; if (failures < 20) $display("FAIL sweep_model cyc=%0d got=%h exp=%h", i, obs, m_exp);
            end
            de_n += int'(video_de); hs_n += int'(video_hs);
            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FT) begin failures++; $display("FAIL fs_period got=%0d exp=%0d", i - last_fs, FT); end
                end
                last_fs = i; fs_n++;
            end
        end
        checks++; if (de_n != HA * VA * 3) begin failures++; $display("FAIL de_count got=%0d exp=%0d", de_n, HA * VA * 3); end
        checks++; if (hs_n != HS * VT * 3) begin failures++; $display("FAIL hs_active got=%0d exp=%0d", hs_n, HS * VT * 3); end
        checks++; if (fs_n != 3) begin failures++; $display("FAIL fs_count got=%0d exp=3", fs_n); end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL frame_cnt3 got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_switch();
        bit seen_fs = 0, done = 0;
        pattern_sel = 3'd0; solid_rgb = 24'h0;
        for (int i = 0; i < 2 * FT; i++) begin
            if (i == FT / 2) begin pattern_sel = 3'd3; solid_rgb = 24'h123456; end
            tick();
            checks++;
            if (obs !== m_exp) begin
                failures++; if (failures < 20) $display("FAIL switch_model cyc=%0d got=%h exp=%h", i, obs, m_exp);
            end
            if (frame_start && i > 0) seen_fs = 1;
            if (seen_fs && !done && video_de) begin
                done = 1; checks++;
                if (video_rgb !== 24'h123456) begin failures++; $display("FAIL switch_first_px got=%h exp=123456", video_rgb); end
            end
        end
    endtask

    task automatic test_random();
        int chg;
        logic [2:0] nsel;
        for (int f = 0; f < 6; f++) begin
            chg = $urandom_range(0, FT - 1);
            nsel = 3'($urandom_range(0, 7));
            for (int i = 0; i < FT; i++) begin
                solid_rgb = 24'($urandom);
                if (i == chg) pattern_sel = nsel;
                tick();
                checks++;
                if (obs !== m_exp) begin
                    failures++; if (failures < 20) $display("FAIL random_model f=%0d cyc=%0d got=%h exp=%h", f, i, obs, m_exp);
                end
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [67:0] idle0;
        pattern_sel = 3'd2;
        repeat (37) begin
            tick(); checks++;
            if (obs !== m_exp) begin failures++; $display("FAIL en_run got=%h exp=%h", obs, m_exp); end
        end
        enable = 1'b0;
        tick(); checks++;
        if (video_de !== 1'b0 || video_hs !== 1'b0 || video_vs !== 1'b0 || video_rgb !== 24'h0) begin
            failures++; $display("FAIL disable_idle got=%h exp=%h", obs, m_exp);
        end
        repeat (4) begin
            tick(); checks++;
            if (obs !== m_exp) begin failures++; $display("FAIL disabled_hold got=%h exp=%h", obs, m_exp); end
        end
        enable = 1'b1;
        tick(); checks++;
        if (frame_start !== 1'b1 || video_hs !== 1'b1 || video_vs !== 1'b1) begin
            failures++; $display("FAIL reenable_fs got=%b%b%b exp=111", frame_start, video_hs, video_vs);
        end
        for (int i = 0; i < 60; i++) begin
            tick(); checks++;
            if (obs !== m_exp) begin failures++; $display("FAIL reenable_run cyc=%0d got=%h exp=%h", i, obs, m_exp); end
        end
        // asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        idle0 = exp_out(-1, 3'd0, 0, 24'h0, 16'h0);
        checks++;
        if (obs !== idle0) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, idle0); end
        apply_reset();
    endtask

    task automatic test_box();
        int whites;
        apply_reset();
        pattern_sel = 3'd4; enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            whites = 0;
            for (int i = 0; i < FT; i++) begin
                tick(); checks++;
                if (obs !== m_exp) begin
                    failures++; if (failures < 20) $display("FAIL box_model k=%0d cyc=%0d got=%h exp=%h", k, i, obs, m_exp);
                end
                if (video_de && video_rgb == 24'hFFFFFF) whites++;
                if (video_de && pixel_ypos == 12'd2 && pixel_xpos == 12'((k - 1) % 13)) begin
                    checks++;
                    if (video_rgb !== 24'hFFFFFF) begin failures++; $display("FAIL box_left k=%0d got=%h exp=ffffff", k, video_rgb); end
                end
            end
            checks++;
            if (whites != BOX * BOX) begin failures++; $display("FAIL box_area k=%0d got=%0d exp=%0d", k, whites, BOX * BOX); end
        end
    endtask

    task automatic test_fcnt_wrap();
        bit seen = 0;
        tick();
        force dut.r_frame_cnt = 16'hFFFF;
        #1 release dut.r_frame_cnt;
        m_fc = 16'hFFFF;
        for (int i = 0; i < FT + 5; i++) begin
            tick(); checks++;
            if (obs !== m_exp) begin
                failures++; if (failures < 20) $display("FAIL wrap_model cyc=%0d got=%h exp=%h", i, obs, m_exp);
            end
            if (frame_start && !seen) begin
                seen = 1; checks++;
                if (frame_cnt !== 16'h0000) begin failures++; $display("FAIL fcnt_wrap got=%h exp=0000", frame_cnt); end
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL fcnt_wrap_timeout got=0 exp=1"); end
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; pattern_sel = 3'd0; solid_rgb = 24'h0;
        m_pos = 0; m_pat = 3'd0; m_box_cur = 0; m_box_next = 0; m_fc = 16'h0; m_exp = '0;
        test_reset();
        test_sweep();
        test_switch();
        test_random();
        test_enable_reset();
        test_box();
        test_fcnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
